// File: rtl/adder_serial_param.sv
// Multi-cycle serial adder/subtractor: one SLICE-bit adder is reused over
// WIDTH/SLICE cycles, with a valid/ready input handshake and a done pulse.
module adder_serial_param #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             din_en,
    output logic             din_rdy,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             ovf_out,
    output logic             dout_en
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_badParams
            $error("adder_serial_param: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    logic             r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_dout;

    logic [SLICE:0]   w_sliceSum;
    logic             w_carryIntoMsb;
    logic [WIDTH-1:0] w_aNext;
    logic [WIDTH-1:0] w_bNext;
    logic [WIDTH-1:0] w_workNext;

    // Operands are shifted right each cycle so the slice adder always sees bits [SLICE-1:0].
    assign w_sliceSum = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]}
                      + {{SLICE{1'b0}}, r_carry};
    assign w_carryIntoMsb = r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_sliceSum[SLICE-1];

    generate
        if (SLICE == WIDTH) begin : g_singleSlice
            assign w_aNext    = '0;
            assign w_bNext    = '0;
            assign w_workNext = w_sliceSum[SLICE-1:0];
        end else begin : g_multiSlice
            assign w_aNext    = {{SLICE{1'b0}}, r_a[WIDTH-1:SLICE]};
            assign w_bNext    = {{SLICE{1'b0}}, r_b[WIDTH-1:SLICE]};
            assign w_workNext = {w_sliceSum[SLICE-1:0], r_work[WIDTH-1:SLICE]};
        end
    endgenerate

    // Result registers only move on the final slice, so they hold the old result while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STATE_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_dout <= 1'b0;
            case (r_state)
                STATE_IDLE: begin
                    if (din_en) begin
                        r_a     <= a_in;
                        r_b     <= b_in ^ {WIDTH{sub}};
                        r_carry <= carry_in ^ sub;
                        r_cnt   <= '0;
                        r_state <= STATE_BUSY;
                    end
                end
                default: begin
                    r_a     <= w_aNext;
                    r_b     <= w_bNext;
                    r_work  <= w_workNext;
                    r_carry <= w_sliceSum[SLICE];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_SLICE) begin
                        r_cnt   <= '0;
                        r_state <= STATE_IDLE;
                        r_sum   <= w_workNext;
                        r_cout  <= w_sliceSum[SLICE];
                        r_ovf   <= w_carryIntoMsb ^ w_sliceSum[SLICE];
                        r_dout  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign din_rdy   = (r_state == STATE_IDLE) && !rst;
    assign sum_out   = r_sum;
    assign carry_out = r_cout;
    assign ovf_out   = r_ovf;
    assign dout_en   = r_dout;

endmodule

// File: doc/adder_serial_param.md
# adder_serial_param

Parametrised multi-cycle serial adder/subtractor. It reuses a single SLICE-bit adder over WIDTH/SLICE clock cycles to add or subtract two WIDTH-bit operands. It supports a valid/ready input handshake, a one-cycle done pulse, a signed overflow flag and result holding. It succeeds the fixed 64/16 serial adder and serves the same datapath role where area matters more than throughput.

## Interface
- WIDTH, 64, operand and result width; must be a multiple of SLICE (elaboration error otherwise).
- SLICE, 16, width of the single physical adder; 1 ≤ SLICE ≤ WIDTH.
- NSLICE (localparam), WIDTH/SLICE, number of slice cycles; NSLICE = 1 is legal.

- clk  input  1  clock; all logic is on the rising edge. One clock domain only.
- rst  input  1  reset, synchronous, active-high.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- carry_in  input  1  carry-in (add) or inverted borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- din_en  input  1  input valid.
- din_rdy  output  1  ready to accept; equals (state == IDLE) && !rst.
- sum_out  output  WIDTH  last completed result.
- carry_out  output  1  raw carry out of the MSB slice for the last result.
- ovf_out  output  1  two's-complement signed overflow of the last result.
- dout_en  output  1  one-cycle pulse marking a new result.

## Operation
- Reset behaviour:
  - rst = 1 at an edge forces state IDLE.
  - sum_out, carry_out, ovf_out, dout_en, slice counter and working registers all reset to 0.
  - din_rdy = 0 while rst is high.
- Accept condition: din_en && din_rdy at an edge. On accept, capture:
  - a_in;
  - b_in XOR {WIDTH{sub}};
  - the initial carry, c0 = carry_in XOR sub.
- Arithmetic: the result is a + (b ^ {WIDTH{sub}}) + (carry_in ^ sub), modulo 2^WIDTH.
  - sub = 1, carry_in = 0 gives a − b.
  - sub = 1, carry_in = 1 gives a − b − 1.
  - carry_out is not inverted; in sub mode carry_out = 0 means a borrow occurred.
- State machine:
  - IDLE → BUSY on accept.
  - BUSY: counter k = 0..NSLICE−1. Each cycle adds slice k of A and B plus the registered carry. It writes sum bits [k·SLICE +: SLICE] into a working register and registers the slice carry.
  - BUSY → IDLE after the cycle where k = NSLICE−1. At that edge, load the working sum into sum_out, load the final carry into carry_out and ovf_out, and set dout_en for the next cycle.
- Overflow: ovf_out = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1), computed inside the last slice.
- Output hold: sum_out, carry_out and ovf_out change only at completion. They hold the previous result during BUSY and indefinitely in IDLE.
- din_en during BUSY is ignored; operands are not re-sampled.

## Timing
- Accept edge ends cycle T. BUSY occupies cycles T+1..T+NSLICE.
- dout_en = 1 in cycle T+NSLICE+1 only, with the new sum_out, carry_out and ovf_out valid from that cycle.
- Latency from accept to dout_en is NSLICE+1 cycles; for the default parameters, 5.
- din_rdy = 1 in the dout_en cycle. A new accept in that cycle is legal, so back-to-back throughput is one result per NSLICE+1 cycles.
- din_rdy = 0 throughout T+1..T+NSLICE.
- Reset mid-operation: the in-flight operation is discarded and no dout_en is issued for it. Outputs are 0 from the cycle after the reset edge, and din_rdy = 1 on the first cycle with rst low.
- rst and din_en high together: reset wins and nothing is accepted.

## Test plan
1. WIDTH=64, SLICE=16: a=FFFF_FFFF_FFFF_FFFF, b=1, carry_in=0, sub=0 accepted at T -> dout_en at T+5, sum_out=0, carry_out=1, ovf_out=0; din_rdy low T+1..T+4.
2. Signed overflow on add: a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum_out=8000_0000_0000_0000, carry_out=0, ovf_out=1.
3. Subtraction: a=0x10, b=0x20, carry_in=0, sub=1 -> sum_out=FFFF_FFFF_FFFF_FFF0, carry_out=0 (borrow), ovf_out=0.
4. Subtraction overflow: a=8000_0000_0000_0000, b=1, sub=1 -> sum_out=7FFF_FFFF_FFFF_FFFF, carry_out=1, ovf_out=1.
5. Handshake:
   - Hold din_en=1 with changing operands during BUSY -> result reflects only the accepted operands, and sum_out holds the prior result until completion.
   - Second accept in the dout_en cycle -> its dout_en follows 5 cycles later.
6. Reset and parameter sweep:
   - Assert rst at T+2 for one cycle -> no dout_en; all outputs 0; din_rdy=1 on the first cycle after release.
   - Repeat scenarios 1–3 with WIDTH=32/SLICE=8 (latency 5) and with WIDTH=16/SLICE=16 (latency 2).
